uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the downstream consumer of the transmit serial line. It recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) using 8x oversampling.
- It presents each received byte as a one-cycle valid pulse to the local consumer, with framing error reporting.
- Its baud selection (MODE) and oversample ratio (8 ticks per bit) match the transmitter, so a TX/RX pair configured with the same MODE interoperates.

Parameters:
- CLK_FREQ, 50000000, SCLK frequency in Hz.
- OVS, 8, oversample ticks per bit. Fixed at 8; the 3-bit tick counter relies on it.

Ports:
- SCLK  in  1  system clock, all logic on rising edge.
- SCLR  in  1  reset, asynchronous, active-low.
- MODE  in  2  baud select: 0=9600, 1=19200, 2=57600, 3=115200.
- RX_EN  in  1  receive enable; start detection only while high.
- RX  in  1  serial input, asynchronous to SCLK, idles high.
- RX_DATA  out  8  last good byte; holds until the next good frame.
- RX_VALID  out  1  one-SCLK pulse when RX_DATA updates.
- RX_FERR  out  1  one-SCLK pulse on framing error (stop bit low).
- RX_BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (SCLR low, async): state=IDLE; RX_DATA=8'h00; RX_VALID=RX_FERR=RX_BUSY=0; synchronizer flops=1; tick divider, tick counter and bit index cleared.
- Synchronizer: 2 flops on RX; all decisions use the synced value rxs. Input-to-decision latency is 2 SCLK.
- Tick generator: DIV = CLK_FREQ/(8*baud), integer truncation.
  - Free-running counter 0..DIV-1; emits a one-SCLK tick at DIV-1.
  - Uses latched MODE, captured at the IDLE->START transition and while idle.
  - MODE changes mid-frame have no effect.
- Counters: cnt (3-bit) is the tick counter within a bit; idx (3-bit) is the data bit index. All advancement happens only on tick cycles.
- IDLE:
  - On a tick with RX_EN=1 and rxs=0: go to START with cnt=0.
- START:
  - cnt increments per tick.
  - At cnt==3: if rxs=1 the start is a glitch; go to IDLE with no output pulse.
  - At cnt==7: go to DATA with cnt=0, idx=0.
- DATA:
  - At cnt==3: shift rxs into the MSB of the shift register (shift right).
  - At cnt==7: if idx==7 go to STOP with cnt=0; else idx+1.
- STOP:
  - At cnt==3 with rxs=1: RX_DATA<=shift register, RX_VALID=1 for one cycle, go to IDLE. Leaving at mid-stop allows back-to-back frames with zero idle bits.
  - At cnt==3 with rxs=0: RX_FERR=1 for one cycle, RX_DATA unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1 on a tick, then go to IDLE. This means a break condition produces exactly one RX_FERR.
- RX_EN deasserted mid-frame: the frame completes normally. RX_EN only gates new start detection.
- RX_VALID and RX_FERR are never high in the same cycle.
- There is no consumer backpressure: a byte not taken is overwritten by the next good frame.
- Latency: RX_VALID rises about 9.5 bit times after the start-bit falling edge, plus synchronizer delay and up to one tick of detection delay.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled at cnt==3.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - Adds output port RX_PERR (1 bit), a one-SCLK pulse coincident with the stop-bit decision if parity failed.
  - On parity failure RX_DATA is still updated and RX_VALID still pulses. Framing error takes priority: with a bad stop bit, RX_FERR pulses and RX_PERR does not.
- Undefined: no PARITY state and no RX_PERR port; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - MODE-to-baud constants (9600, 19200, 57600, 115200).
  - OVS=8.
  - Divider function DIV(clk, baud), also used by the transmitter side.
- One sub-module: uart_rx_tick, containing the divider and MODE latch with a tick output. It is kept separate from the transmitter's generator because it needs async active-low reset.

Test Plan:
- Reset: hold SCLR=0 with RX toggling -> outputs 0, RX_DATA=8'h00; after release and one idle frame time, RX_BUSY=0 and no pulses.
- Good frame, CLK_FREQ=50M, MODE=3 (DIV=54, 432 SCLK/bit): send 8'hA5 -> exactly one RX_VALID with RX_DATA=8'hA5, RX_FERR=0. Repeat for 8'h00, 8'hFF, 8'h01, 8'h80.
- Back-to-back: 8'h3C then 8'hC3 with no idle bits -> two RX_VALID pulses, data 8'h3C then 8'hC3, about 10 bit times apart.
- Glitch: RX low for 2 ticks (108 SCLK) then high -> return to IDLE, no RX_VALID/RX_FERR; a following 8'h5A is received correctly.
- Framing: 8'h55 with stop bit low, then RX held low 3 bit times -> single RX_FERR, RX_DATA keeps its previous value; after RX goes high, 8'h12 is received.
- Reset mid-frame / RX_EN: SCLR low during D4 -> IDLE immediately with no pulse. Separately, RX_EN=0 at the start edge -> frame ignored; RX_EN dropped during D2 -> frame still delivered. With UART_RX_PARITY_EN: 8'h07 with parity=0 -> RX_VALID plus RX_PERR.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, MODE-to-baud table,
// oversample ratio and the baud divider helper. The transmitter uses the same
// divider helper, so a TX/RX pair built with the same MODE settles on the same
// tick period.
package uart_pkg;

    localparam int unsigned OVS = 8;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Clocks per oversample tick, truncating.
    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / (OVS * baud);
    endfunction

    function automatic int unsigned mode_baud(input logic [1:0] mode);
        case (mode)
            2'd0:    return BAUD_9600;
            2'd1:    return BAUD_19200;
            2'd2:    return BAUD_57600;
            default: return BAUD_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator for the receiver.
// Ports:
//   SCLK     system clock
//   SCLR     asynchronous active-low reset
//   mode     baud select (0=9600, 1=19200, 2=57600, 3=115200)
//   mode_ld  latch mode this cycle (receiver idle)
//   tick     one-SCLK pulse every DIV clocks
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       SCLK,
    input  logic       SCLR,
    input  logic [1:0] mode,
    input  logic       mode_ld,
    output logic       tick
);

    localparam int unsigned DW = $clog2(baud_div(CLK_FREQ, BAUD_9600)) + 1;

    localparam logic [DW-1:0] TOP_0 = DW'(baud_div(CLK_FREQ, BAUD_9600) - 1);
    localparam logic [DW-1:0] TOP_1 = DW'(baud_div(CLK_FREQ, BAUD_19200) - 1);
    localparam logic [DW-1:0] TOP_2 = DW'(baud_div(CLK_FREQ, BAUD_57600) - 1);
    localparam logic [DW-1:0] TOP_3 = DW'(baud_div(CLK_FREQ, BAUD_115200) - 1);

    logic [1:0]    mode_q;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_top_c;

    // Terminal count for the latched mode.
    always_comb begin
        div_top_c = TOP_3;
        case (mode_q)
            2'd0:    div_top_c = TOP_0;
            2'd1:    div_top_c = TOP_1;
            2'd2:    div_top_c = TOP_2;
            default: div_top_c = TOP_3;
        endcase
    end

    // Free-running divider; >= so a shorter period after a mode change wraps cleanly.
    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            mode_q  <= 2'd0;
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            if (mode_ld) begin
                mode_q <= mode;
            end
            if (div_cnt >= div_top_c) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 with UART_RX_PARITY_EN) recovered with 8x
// oversampling, each bit sampled at tick 3 of its 8-tick window.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit + RX_PERR port).
// Ports:
//   SCLK      system clock
//   SCLR      asynchronous active-low reset
//   MODE      baud select, latched while idle
//   RX_EN     enables start detection only
//   RX        asynchronous serial input, idles high
//   RX_DATA   last good byte
//   RX_VALID  one-cycle pulse when RX_DATA updates
//   RX_FERR   one-cycle pulse on a low stop bit
//   RX_BUSY   high while not idle
//   RX_PERR   (parity build) one-cycle parity-failure pulse with RX_VALID
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned OVS      = 8
) (
    input  logic       SCLK,
    input  logic       SCLR,
    input  logic [1:0] MODE,
    input  logic       RX_EN,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_FERR,
    output logic       RX_BUSY
`ifdef UART_RX_PARITY_EN
    ,
    output logic       RX_PERR
`endif
);

    import uart_pkg::*;

    localparam logic [2:0] CNT_MID  = 3'(OVS / 2 - 1);
    localparam logic [2:0] CNT_LAST = 3'(OVS - 1);

    logic       rx_meta;
    logic       rxs;
    logic       tick;

    rx_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_d;
`endif

    uart_rx_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .SCLK    (SCLK),
        .SCLR    (SCLR),
        .mode    (MODE),
        .mode_ld (state_q == IDLE),
        .tick    (tick)
    );

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge SCLK or negedge SCLR) begin
        if (!SCLR) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= 3'd0;
            shreg_q  <= 8'h00;
            RX_DATA  <= 8'h00;
            RX_VALID <= 1'b0;
            RX_FERR  <= 1'b0;
            RX_BUSY  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            RX_PERR  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            RX_DATA  <= data_d;
            RX_VALID <= valid_d;
            RX_FERR  <= ferr_d;
            RX_BUSY  <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            RX_PERR  <= perr_d;
`endif
        end
    end

    // Next-state and output decode; everything advances only on ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = RX_DATA;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (RX_EN && !rxs) begin
                        state_d = START;
                        cnt_d   = 3'd0;
                    end
                end
                START: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CNT_MID && rxs) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CNT_MID) begin
                        shreg_d = {rxs, shreg_q[7:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = 3'd0;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CNT_MID) begin
                        par_d = rxs;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = STOP;
                        cnt_d   = 3'd0;
                    end
                end
`endif
                // Decide at mid-stop so a following start edge is never missed.
                STOP: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CNT_MID) begin
                        if (rxs) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = ^{shreg_q, par_q};
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end
                end
                // Absorb a break so it reports only one framing error.
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized and directed serial frames at
// MODE=3 with a scoreboard of expected receive events.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned DIV      = CLK_FREQ / (8 * 115200);
    localparam int unsigned BITC     = 8 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    logic       SCLK;
    logic       SCLR;
    logic [1:0] MODE;
    logic       RX_EN;
    logic       RX;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_FERR;
    logic       RX_BUSY;
`ifdef UART_RX_PARITY_EN
    logic       RX_PERR;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [7:0] prev_good = 8'h00;
    longint cyc = 0;
    longint last_vcyc = 0;
    longint prev_vcyc = 0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .OVS      (8)
    ) dut (
        .SCLK     (SCLK),
        .SCLR     (SCLR),
        .MODE     (MODE),
        .RX_EN    (RX_EN),
        .RX       (RX),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_FERR  (RX_FERR),
        .RX_BUSY  (RX_BUSY)
`ifdef UART_RX_PARITY_EN
        ,
        .RX_PERR  (RX_PERR)
`endif
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;
    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge SCLK) begin
        exp_t e;
        if (SCLR) begin
            if (RX_VALID && RX_FERR) begin
                chk("valid_ferr_exclusive", 32'(1), 32'(0));
            end
            if (RX_VALID || RX_FERR) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {RX_VALID, RX_FERR, 22'd0, RX_DATA}, 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_ferr", 32'(RX_FERR), 32'(e.ferr));
                    chk("rx_data", 32'(RX_DATA), 32'(e.data));
`ifdef UART_RX_PARITY_EN
                    chk("rx_perr", 32'(RX_PERR), 32'(e.perr));
`endif
                end
                if (RX_VALID) begin
                    prev_vcyc = last_vcyc;
                    last_vcyc = cyc;
                end
            end
`ifdef UART_RX_PARITY_EN
            else if (RX_PERR) begin
                chk("stray_perr", 32'(1), 32'(0));
            end
`endif
        end
    end

    task automatic send_bit(input logic b);
        RX = b;
        repeat (BITC) @(posedge SCLK);
    endtask

    // hook_act: 1 drop RX_EN, 2 assert reset, 3 change MODE, 4 check busy.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int hook_bit, input int hook_act, input bit expect_evt);
        exp_t e;
        if (expect_evt) begin
            e.ferr = ~stop;
            e.perr = stop & par_flip;
            e.data = stop ? d : prev_good;
            exp_q.push_back(e);
            if (stop) prev_good = d;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            if (i == hook_bit) begin
                case (hook_act)
                    1: RX_EN = 1'b0;
                    2: begin
                        SCLR = 1'b0;
                        @(negedge SCLK);
                        chk("midreset_busy", 32'(RX_BUSY), 32'(0));
                        chk("midreset_valid", 32'(RX_VALID), 32'(0));
                        chk("midreset_data", 32'(RX_DATA), 32'(0));
                    end
                    3: MODE = 2'd0;
                    4: begin
                        @(negedge SCLK);
                        chk("busy_in_frame", 32'(RX_BUSY), 32'(1));
                    end
                    default: ;
                endcase
            end
            repeat (BITC) @(posedge SCLK);
        end
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        if (hook_act == 3) MODE = 2'd3;
        send_bit(stop);
    endtask

    initial begin
        logic [7:0] dir_bytes[5];
        longint gap;
        int unsigned w;
        dir_bytes = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};

        SCLR = 1'b0; RX = 1'b1; RX_EN = 1'b1; MODE = 2'd3;
        repeat (6) begin
            @(posedge SCLK);
            RX = ~RX;
        end
        RX = 1'b1;
        @(negedge SCLK);
        chk("reset_data", 32'(RX_DATA), 32'(0));
        chk("reset_valid", 32'(RX_VALID), 32'(0));
        chk("reset_ferr", 32'(RX_FERR), 32'(0));
        chk("reset_busy", 32'(RX_BUSY), 32'(0));
        @(posedge SCLK);
        SCLR = 1'b1;
        repeat (2 * BITC) @(posedge SCLK);
        @(negedge SCLK);
        chk("idle_busy", 32'(RX_BUSY), 32'(0));

        // Directed good frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(dir_bytes[i], 1'b1, 1'b0, (i == 0) ? 2 : -1, (i == 0) ? 4 : 0, 1'b1);
        end

        // Back-to-back frames with no idle bits.
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0, -1, 0, 1'b1);
        gap = last_vcyc - prev_vcyc;
        chk("b2b_gap_in_window",
            32'((gap >= longint'(FRAME_BITS * BITC - 2 * DIV)) &&
                (gap <= longint'(FRAME_BITS * BITC + 2 * DIV))), 32'(1));

        // Glitch of two ticks on an idle line.
        RX = 1'b0;
        repeat (2 * DIV) @(posedge SCLK);
        RX = 1'b1;
        repeat (BITC) @(posedge SCLK);
        @(negedge SCLK);
        chk("glitch_busy", 32'(RX_BUSY), 32'(0));
        send_frame(8'h5A, 1'b1, 1'b0, -1, 0, 1'b1);

        // Framing error followed by a break.
        send_frame(8'h55, 1'b0, 1'b0, -1, 0, 1'b1);
        repeat (2 * BITC) @(posedge SCLK);
        @(negedge SCLK);
        chk("break_busy", 32'(RX_BUSY), 32'(1));
        RX = 1'b1;
        repeat (BITC) @(posedge SCLK);
        @(negedge SCLK);
        chk("after_break_busy", 32'(RX_BUSY), 32'(0));
        send_frame(8'h12, 1'b1, 1'b0, -1, 0, 1'b1);

        // Reset during D4, held until the line is idle.
        send_frame(8'h9E, 1'b1, 1'b0, 4, 2, 1'b0);
        prev_good = 8'h00;
        @(posedge SCLK);
        SCLR = 1'b1;
        repeat (BITC) @(posedge SCLK);

        // RX_EN low across a whole frame: ignored.
        RX_EN = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0, -1, 0, 1'b0);
        RX_EN = 1'b1;
        repeat (BITC) @(posedge SCLK);

        // RX_EN dropped during D2: frame still delivered.
        send_frame(8'hB4, 1'b1, 1'b0, 2, 1, 1'b1);
        RX_EN = 1'b1;

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1, 0, 1'b1);
`endif

        // Randomized frames; one has MODE disturbed mid-frame.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            logic       flip;
            d    = 8'($urandom);
`ifdef UART_RX_PARITY_EN
            flip = 1'($urandom_range(0, 1));
`else
            flip = 1'b0;
`endif
            send_frame(d, 1'b1, flip, (i == 1) ? 3 : -1, (i == 1) ? 3 : 0, 1'b1);
            repeat ($urandom_range(0, BITC)) @(posedge SCLK);
        end

        // Bounded drain of outstanding expectations.
        w = 0;
        while (exp_q.size() != 0 && w < 4 * BITC) begin
            @(posedge SCLK);
            w++;
        end
        @(negedge SCLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
